// File: rtl/sort_stream_unpacker.sv
// Serialises one sorted 8-element vector per handshake into a beat stream, element 0 first.
// Define SORT_UNPACK_CHECK_EN to build the sticky sortedness checker behind o_sort_err.
module sort_stream_unpacker #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [DATA_W*8-1:0] i_vec,
    input  logic                i_vec_valid,
    output logic                o_vec_ready,
    output logic [DATA_W-1:0]   o_data,
    output logic [2:0]          o_index,
    output logic                o_valid,
    output logic                o_last,
    input  logic                i_out_ready,
    input  logic                i_flush,
    output logic [CNT_W-1:0]    o_vec_cnt,
    output logic                o_sort_err
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [DATA_W*8-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]    vec_cnt_q, vec_cnt_d;
    logic [DATA_W-1:0]   elems [8];
    logic                send, beat, accept;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            elems[k] = buf_q[DATA_W*k +: DATA_W];
        end
    end

    assign send = (state_q == StSend);
    assign beat = send && i_out_ready;

    // The last beat frees the buffer in the same cycle, so a new vector can follow with no bubble.
    assign o_vec_ready = !i_flush && ((state_q == StIdle) || (beat && (cnt_q == 3'd7)));
    assign accept      = i_vec_valid && o_vec_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        vec_cnt_d = vec_cnt_q;
        if (i_flush) begin
            state_d = StIdle;
            cnt_d   = 3'd0;
        end else begin
            if (beat) begin
                if (cnt_q == 3'd7) begin
                    vec_cnt_d = vec_cnt_q + 1'b1;
                    state_d   = StIdle;
                    cnt_d     = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            if (accept) begin
                buf_d   = i_vec;
                cnt_d   = 3'd0;
                state_d = StSend;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 3'd0;
            buf_q     <= '0;
            vec_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            vec_cnt_q <= vec_cnt_d;
        end
    end

    assign o_valid   = send;
    assign o_index   = cnt_q;
    assign o_last    = send && (cnt_q == 3'd7);
    assign o_data    = send ? elems[cnt_q] : '0;
    assign o_vec_cnt = vec_cnt_q;

`ifdef SORT_UNPACK_CHECK_EN
    logic unsorted;
    logic sort_err_q, sort_err_d;

    always_comb begin
        unsorted = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (i_vec[DATA_W*k +: DATA_W] > i_vec[DATA_W*(k+1) +: DATA_W]) begin
                unsorted = 1'b1;
            end
        end
    end

    always_comb begin
        sort_err_d = sort_err_q;
        if (i_flush) begin
            sort_err_d = 1'b0;
        end else if (accept && unsorted) begin
            sort_err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sort_err_q <= 1'b0;
        end else begin
            sort_err_q <= sort_err_d;
        end
    end

    assign o_sort_err = sort_err_q;
`else
    assign o_sort_err = 1'b0;
`endif

endmodule

// File: doc/sort_stream_unpacker.md
Name: sort_stream_unpacker

Overview:
- Consumer-side companion to the 8-lane pipelined sorter.
- Accepts one sorted 8-element parallel vector (DATA_W*8 bits) per handshake and streams it out one element per beat, element 0 first.
- The output beats carry index, last-flag and valid/ready backpressure.
- Sits between the sorter output register and downstream serial logic (FIFO, bus writer).

Parameters:
- DATA_W, 8, width of one element in bits; vector width is DATA_W*8.
- CNT_W, 16, width of the completed-vector counter o_vec_cnt.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_vec  input  DATA_W*8  sorted vector; element k is bits [DATA_W*(k+1)-1 : DATA_W*k].
- i_vec_valid  input  1  i_vec is valid this cycle.
- o_vec_ready  output  1  block can accept i_vec this cycle.
- o_data  output  DATA_W  current element.
- o_index  output  3  element index of o_data (0..7).
- o_valid  output  1  o_data, o_index and o_last are valid.
- o_last  output  1  current beat is element 7.
- i_out_ready  input  1  downstream accepts the beat.
- i_flush  input  1  synchronous abort of the vector in flight.
- o_vec_cnt  output  CNT_W  number of vectors fully streamed.
- o_sort_err  output  1  sticky sortedness violation flag (optional feature).

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - state=IDLE, buffer=0, cnt=0, o_vec_cnt=0, o_sort_err=0.
  - Outputs: o_valid=0, o_last=0, o_data=0, o_index=0.
  - o_vec_ready=1 from the first clock edge after release.
- Definitions:
  - Accept = i_vec_valid && o_vec_ready.
  - Beat = o_valid && i_out_ready.
- State IDLE:
  - o_vec_ready=1, o_valid=0.
  - On accept: latch i_vec into buffer, cnt<=0, go to SEND.
- State SEND:
  - o_valid=1; o_data=buffer element cnt; o_index=cnt; o_last=(cnt==7).
  - On beat with cnt<7: cnt<=cnt+1.
  - On beat with cnt==7: o_vec_cnt<=o_vec_cnt+1, which wraps at 2^CNT_W.
    - If accept occurs in the same cycle: latch the new vector, cnt<=0, stay in SEND. No bubble.
    - Otherwise: go to IDLE.
- o_vec_ready:
  - Equals 1 in IDLE, or in SEND when cnt==7 && i_out_ready.
  - Combinational from state, cnt and i_out_ready; it does not depend on i_vec_valid.
- Latency and throughput:
  - Accept in cycle N gives the first beat (o_valid=1) in cycle N+1.
  - Sustained throughput is 8 beats per vector, with 0 idle cycles under continuous valid/ready.
- Backpressure:
  - While o_valid && !i_out_ready, o_data, o_index and o_last hold stable.
  - o_valid never drops without a beat, except on flush.
- Flush (i_flush=1):
  - Next cycle: state=IDLE, cnt=0, o_valid=0. o_vec_cnt is not incremented.
  - o_vec_ready is forced to 0 during the flush cycle, so there is no accept.
  - Flush overrides a simultaneous beat and accept.
  - Flush in IDLE has no effect except clearing o_sort_err.
- Reset mid-vector: the vector is discarded immediately; there is no partial completion.
- Outputs: all are derived from registers, except o_vec_ready (see above).

Optional Feature:
- Macro: SORT_UNPACK_CHECK_EN.
- Defined:
  - On each accept, compare adjacent elements of i_vec as unsigned values.
  - If any element k > element k+1 (k=0..6), o_sort_err<=1 on the next cycle.
  - o_sort_err is sticky until reset or i_flush.
  - Streaming is unaffected.
- Undefined:
  - No comparator logic is built and o_sort_err is tied to 0.
  - The port is still present.

Test Plan:
- Reset, then i_vec={8'h07,8'h06,...,8'h00} (element k=k), valid for 1 cycle, i_out_ready=1 -> 8 consecutive beats with o_data=0..7 and o_index=0..7; o_last only on beat 8; o_vec_cnt=1; o_vec_ready=0 during beats 1-7.
- Two vectors held valid back-to-back, i_out_ready=1 -> 16 contiguous beats with no o_valid gap; second vector accepted in the cycle of the first vector's o_last beat; o_vec_cnt=2.
- i_out_ready=0 for 3 cycles at index 4 (value 8'h14 of vector 8'h10..8'h17) -> o_data=8'h14 and o_index=4 held stable for 3 cycles; stream then resumes 8'h15..8'h17.
- i_flush asserted at index 3 with i_vec_valid=1 -> o_valid=0 next cycle; no accept in the flush cycle; o_vec_cnt unchanged; the next vector starts at index 0.
- SORT_UNPACK_CHECK_EN defined, i_vec elements {0,1,2,9,4,5,6,7} -> o_sort_err=1 one cycle after accept and held through the following sorted vector; cleared by i_flush. Without the macro -> o_sort_err=0 throughout.
- Assert i_rst_n=0 asynchronously mid-SEND at index 5 -> o_valid, o_last and o_vec_cnt go to 0 immediately, without waiting for a clock edge; o_vec_ready=1 after release.
